counter_seq_checker: RTL and testbench
======================================

# counter_seq_checker

Hardware sequence monitor that sits directly downstream of the parameterized free-running `counter` and consumes its `q` output every clock. It acquires lock on the up-count sequence, then flags any sample that is not the previous value plus one (modulo 2^WIDTH). It also counts wrap-arounds and errors, so counter integrity is observable on silicon, not only in simulation.

## Interface
- `WIDTH`, 4: width of monitored count; must match upstream counter.
- `LOCK_LEN`, 4: consecutive good increments required before lock; range 1..255.
- `CNT_W`, 8: width of `err_count` and `wrap_count`.

- `clk`  in  1  rising-edge clock; same clock as upstream counter.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `q`  in  WIDTH  count value from upstream counter.
- `check_en`  in  1  1 = monitor active; 0 = return to IDLE.
- `clear`  in  1  synchronous clear of statistics.
- `locked`  out  1  sequence locked (state LOCKED).
- `err_pulse`  out  1  one-cycle pulse per detected mismatch.
- `wrap_pulse`  out  1  one-cycle pulse per legal all-ones→0 transition while locked.
- `err_count`  out  CNT_W  saturating mismatch count.
- `wrap_count`  out  CNT_W  modulo-2^CNT_W wrap count.
- `last_bad`  out  WIDTH  `q` value of most recent mismatch.

## Operation
- Internal registers:
  - `prev` (WIDTH), last sampled `q`.
  - `prev_vld` (1).
  - `run` (8), consecutive good increments.
  - 2-bit state.
- Expected value: `exp = prev + 1`, truncated to WIDTH bits. All-ones → 0 is a legal increment.
- States:
  - **IDLE**
    - `prev_vld` = 0 and `run` = 0.
    - `check_en` = 1 → ACQUIRE.
  - **ACQUIRE**
    - First edge with `prev_vld` = 0: load `prev` = `q`, set `prev_vld`. No compare.
    - After that, on each edge:
      - `q` == `exp`: increment `run`. When `run` reaches `LOCK_LEN`, go to LOCKED.
      - `q` != `exp`: set `run` = 0. No error is counted.
    - `prev` = `q` on every edge.
  - **LOCKED**
    - On each edge, compare `q` against `exp`.
    - Match:
      - Stay in LOCKED.
      - If `prev` is all-ones and `q` == 0: pulse `wrap_pulse` and increment `wrap_count`.
    - Mismatch:
      - Pulse `err_pulse`.
      - `err_count` += 1, saturating at 2^CNT_W−1.
      - `last_bad` = `q`.
      - Set `run` = 0 and go to ACQUIRE with `prev` = `q`, `prev_vld` = 1 (resync on the bad value).
- `check_en` = 0 in any state → IDLE on the next edge.
  - That edge performs no compare and no pulses.
  - Statistics hold their values.
- `clear` = 1:
  - Zeroes `err_count`, `wrap_count` and `last_bad`.
  - FSM, `prev` and `run` are unaffected.
  - If an error or wrap occurs on the same edge, the counter's result is 1: clear first, then increment. `last_bad` takes the new bad value.
- `locked` is 1 exactly while state is LOCKED.

## Timing
- All outputs are registered and change only on the rising edge of `clk`, or on reset assertion.
- Reset values (`reset` = 0, asynchronous):
  - state IDLE.
  - `locked`, `err_pulse`, `wrap_pulse` = 0.
  - `err_count`, `wrap_count` = 0.
  - `last_bad` = 0.
  - `prev` = 0, `prev_vld` = 0, `run` = 0.
- Reset deassertion is synchronized by the user. The first active edge after release evaluates normally.
- Latency: `q` sampled at edge k → `err_pulse`/`wrap_pulse` high during cycle k..k+1, for one cycle only.
- Lock time with `check_en` held high from IDLE and a clean count:
  - 1 edge to enter ACQUIRE.
  - 1 edge to load `prev`.
  - `LOCK_LEN` edges of good increments.
  - `locked` rises at the edge of the `LOCK_LEN`-th good compare, i.e. `LOCK_LEN`+2 edges after `check_en` is first sampled high.
- Back-to-back mismatches: the first produces `err_pulse`. Later ones occur in ACQUIRE and produce no pulse until lock is re-acquired.
- Reset asserted mid-operation: everything returns to reset values immediately. Any pulse in flight is dropped.
- `err_count` saturation: once at max, further errors still pulse `err_pulse` and update `last_bad`; the count stays at max.

## Test plan
- **Clean lock and run:**
  - Setup: WIDTH=4, LOCK_LEN=4; upstream counter released from reset; `check_en` = 1 for 40 cycles.
  - Response:
    - `locked` rises 6 edges after `check_en` is sampled.
    - `err_pulse` never fires.
    - `wrap_pulse` fires on each 15→0 sample.
    - `wrap_count` = 2 after 40 cycles.
- **Single glitch:**
  - Stimulus: force `q` = 9 where 6 is expected, while locked.
  - Response:
    - One `err_pulse`; `err_count` = 1; `last_bad` = 9; `locked` falls.
    - Lock is re-acquired 4 edges later with the sequence continuing 10, 11, 12, 13.
- **Simultaneous clear + error:**
  - Stimulus: `err_count` = 3; assert `clear` on the edge where a mismatch is sampled.
  - Response: `err_count` = 1 and `last_bad` = the new bad value.
- **Saturation:**
  - Stimulus: CNT_W=2; inject 5 isolated errors, each followed by re-lock.
  - Response: `err_count` stops at 3; 5 `err_pulse` pulses are observed.
- **Disable:**
  - Stimulus: drop `check_en` while locked, then inject a bad value.
  - Response:
    - IDLE next edge; `locked` = 0.
    - No `err_pulse`; statistics unchanged.
- **Async reset mid-run:**
  - Stimulus: pull `reset` low between edges.
  - Response: all outputs go to 0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/counter_seq_checker_if.sv
// counter_seq_checker_if: sampled count, controls and monitor results of counter_seq_checker
interface counter_seq_checker_if #(parameter int WIDTH = 4, parameter int CNT_W = 8);
  logic [WIDTH-1:0] q;
  logic             check_en;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic             wrap_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] wrap_count;
  logic [WIDTH-1:0] last_bad;
  modport master (output q, check_en, clear,
                  input  locked, err_pulse, wrap_pulse, err_count, wrap_count, last_bad);
  modport slave  (input  q, check_en, clear,
                  output locked, err_pulse, wrap_pulse, err_count, wrap_count, last_bad);
endinterface

// File: rtl/counter_seq_checker.sv
// counter_seq_checker: locks onto an up-counting q stream and flags/counts broken increments and wraps
module counter_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 4,
  parameter int CNT_W    = 8
) (
  input logic                clk,
  input logic                reset,
  counter_seq_checker_if.slave io_bus
);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic             r_prev_vld;
  logic [7:0]       r_run;
  logic             r_locked;
  logic             r_err_pulse;
  logic             r_wrap_pulse;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_wrap_count;
  logic [WIDTH-1:0] r_last_bad;
  logic [WIDTH-1:0] w_exp;
  logic             w_match;
  logic [CNT_W-1:0] w_err_base;
  logic [CNT_W-1:0] w_wrap_base;
  assign w_exp   = r_prev + WIDTH'(1);
  assign w_match = io_bus.q == w_exp;
  // clear on the same edge as an event counts that event on top of zero
  assign w_err_base  = io_bus.clear ? '0 : r_err_count;
  assign w_wrap_base = io_bus.clear ? '0 : r_wrap_count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_prev_vld   <= 1'b0;
      r_run        <= '0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
      r_last_bad   <= '0;
    end else begin
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      if (io_bus.clear) begin
        r_err_count  <= '0;
        r_wrap_count <= '0;
        r_last_bad   <= '0;
      end
      if (!io_bus.check_en) begin
        r_state    <= IDLE;
        r_prev_vld <= 1'b0;
        r_run      <= '0;
        r_locked   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state    <= ACQUIRE;
            r_prev_vld <= 1'b0;
            r_run      <= '0;
          end
          ACQUIRE: begin
            r_prev     <= io_bus.q;
            r_prev_vld <= 1'b1;
            if (r_prev_vld) begin
              r_run <= w_match ? r_run + 8'd1 : '0;
              if (w_match && (r_run + 8'd1 == 8'(LOCK_LEN))) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            r_prev <= io_bus.q;
            if (w_match) begin
              if (&r_prev) begin
                r_wrap_pulse <= 1'b1;
                r_wrap_count <= w_wrap_base + CNT_W'(1);
              end
            end else begin
              // resync on the bad value so a jumped counter re-locks quickly
              r_err_pulse <= 1'b1;
              r_err_count <= &w_err_base ? w_err_base : w_err_base + CNT_W'(1);
              r_last_bad  <= io_bus.q;
              r_run       <= '0;
              r_state     <= ACQUIRE;
              r_locked    <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  assign io_bus.locked     = r_locked;
  assign io_bus.err_pulse  = r_err_pulse;
  assign io_bus.wrap_pulse = r_wrap_pulse;
  assign io_bus.err_count  = r_err_count;
  assign io_bus.wrap_count = r_wrap_count;
  assign io_bus.last_bad   = r_last_bad;
endmodule

// File: tb/tb_counter_seq_checker.sv
// tb_counter_seq_checker: random and directed stimulus checked against a behavioural sequence model
module tb_counter_seq_checker;
  localparam int LOCK_LEN = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int n_pulse2 = 0;
  logic [3:0] cnt = '0;
  logic [3:0] g_bad = '0;
  int m_mode, m_streak, m_prev, m_err8, m_err2, m_wrap, m_last;
  bit m_have, m_locked, m_errp, m_wrapp;
  counter_seq_checker_if #(.WIDTH(4), .CNT_W(8)) b8 ();
  counter_seq_checker_if #(.WIDTH(4), .CNT_W(2)) b2 ();
  counter_seq_checker #(.WIDTH(4), .LOCK_LEN(LOCK_LEN), .CNT_W(8)) u8 (.clk(clk), .reset(reset), .io_bus(b8));
  counter_seq_checker #(.WIDTH(4), .LOCK_LEN(LOCK_LEN), .CNT_W(2)) u2 (.clk(clk), .reset(reset), .io_bus(b2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_have = 0; m_streak = 0; m_prev = 0;
    m_err8 = 0; m_err2 = 0; m_wrap = 0; m_last = 0;
    m_locked = 0; m_errp = 0; m_wrapp = 0;
  endtask
  // mode: 0 waiting, 1 hunting for LOCK_LEN good steps, 2 locked
  task automatic model_step(input int q, input bit en, input bit clr);
    m_errp = 0;
    m_wrapp = 0;
    if (clr) begin m_err8 = 0; m_err2 = 0; m_wrap = 0; m_last = 0; end
    if (!en) begin
      m_mode = 0; m_have = 0; m_streak = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_have) begin
        if (q == (m_prev + 1) % 16) begin
          m_streak++;
          if (m_streak >= LOCK_LEN) m_mode = 2;
        end else m_streak = 0;
      end
      m_have = 1;
      m_prev = q;
    end else begin
      if (q == (m_prev + 1) % 16) begin
        if (q == 0) begin m_wrapp = 1; m_wrap++; end
      end else begin
        m_errp = 1;
        m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
        m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
        m_last = q;
        m_streak = 0;
        m_mode = 1;
      end
      m_prev = q;
    end
    m_locked = (m_mode == 2);
  endtask
  task automatic tick(input logic [3:0] q, input logic en, input logic clr);
    b8.q = q; b8.check_en = en; b8.clear = clr;
    b2.q = q; b2.check_en = en; b2.clear = clr;
    @(posedge clk);
    model_step(int'(q), en, clr);
    @(negedge clk);
    if (b2.err_pulse) n_pulse2++;
    chk("locked", int'(b8.locked), int'(m_locked));
    chk("err_pulse", int'(b8.err_pulse), int'(m_errp));
    chk("wrap_pulse", int'(b8.wrap_pulse), int'(m_wrapp));
    chk("err_count", int'(b8.err_count), m_err8);
    chk("wrap_count", int'(b8.wrap_count), m_wrap % 256);
    chk("last_bad", int'(b8.last_bad), m_last);
    chk("err_count_w2", int'(b2.err_count), m_err2);
    chk("wrap_count_w2", int'(b2.wrap_count), m_wrap % 4);
    chk("err_pulse_w2", int'(b2.err_pulse), int'(m_errp));
  endtask
  task automatic run(input int n);
    repeat (n) begin
      tick(cnt, 1'b1, 1'b0);
      cnt = cnt + 4'd1;
    end
  endtask
  task automatic glitch(input logic clr);
    g_bad = 4'(cnt + 4'd5);
    tick(g_bad, 1'b1, clr);
    cnt = g_bad + 4'd1;
    run(6);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, int'(b8.locked), 0);
    chk({tag, "_err_pulse"}, int'(b8.err_pulse), 0);
    chk({tag, "_wrap_pulse"}, int'(b8.wrap_pulse), 0);
    chk({tag, "_err_count"}, int'(b8.err_count), 0);
    chk({tag, "_wrap_count"}, int'(b8.wrap_count), 0);
    chk({tag, "_last_bad"}, int'(b8.last_bad), 0);
    chk({tag, "_err_count_w2"}, int'(b2.err_count), 0);
  endtask
  initial begin
    b8.q = '0; b8.check_en = 1'b0; b8.clear = 1'b0;
    b2.q = '0; b2.check_en = 1'b0; b2.clear = 1'b0;
    model_reset();
    #3 chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    run(5);
    chk("lock_not_yet", int'(b8.locked), 0);
    run(1);
    chk("lock_at_6", int'(b8.locked), 1);
    run(34);
    chk("clean_wraps", int'(b8.wrap_count), 2);
    chk("clean_errs", int'(b8.err_count), 0);
    run(14);
    tick(4'd9, 1'b1, 1'b0);
    cnt = 4'd10;
    chk("glitch_err", int'(b8.err_count), 1);
    chk("glitch_last", int'(b8.last_bad), 9);
    chk("glitch_unlock", int'(b8.locked), 0);
    run(3);
    chk("relock_pending", int'(b8.locked), 0);
    run(1);
    chk("relock", int'(b8.locked), 1);
    tick(cnt, 1'b1, 1'b1);
    cnt = cnt + 4'd1;
    repeat (3) glitch(1'b0);
    chk("three_errs", int'(b8.err_count), 3);
    g_bad = 4'(cnt + 4'd5);
    tick(g_bad, 1'b1, 1'b1);
    cnt = g_bad + 4'd1;
    chk("clear_err_count", int'(b8.err_count), 1);
    chk("clear_err_last", int'(b8.last_bad), int'(g_bad));
    run(6);
    tick(cnt, 1'b1, 1'b1);
    cnt = cnt + 4'd1;
    n_pulse2 = 0;
    repeat (5) glitch(1'b0);
    chk("sat_count", int'(b2.err_count), 3);
    chk("sat_pulses", n_pulse2, 5);
    chk("sat_wide_count", int'(b8.err_count), 5);
    tick(cnt, 1'b0, 1'b0);
    cnt = cnt + 4'd1;
    chk("disable_unlock", int'(b8.locked), 0);
    tick(4'(cnt + 4'd7), 1'b0, 1'b0);
    chk("disable_no_pulse", int'(b8.err_pulse), 0);
    chk("disable_hold_err", int'(b8.err_count), 5);
    chk("disable_hold_last", int'(b8.last_bad), int'(g_bad));
    run(8);
    repeat (400) begin
      logic en, clr;
      logic [3:0] q;
      en  = $urandom_range(0, 19) != 0;
      clr = $urandom_range(0, 29) == 0;
      q   = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : cnt;
      tick(q, en, clr);
      cnt = q + 4'd1;
    end
    run(10);
    #2 reset = 1'b0;
    model_reset();
    #1 chk_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    run(20);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
